// File: rtl/prio_encoder_hs.sv
// -----------------------------------------------------------------------------
// prio_encoder_hs
//
// Registered N-to-log2(N) priority encoder with valid/ready handshakes on both
// sides. The encoded result of an accepted request vector appears exactly one
// cycle after acceptance. One result per cycle is sustained while the consumer
// keeps out_ready high. Zero and multi-hot vectors are flagged, and each such
// vector bumps a saturating error counter.
//
// Optional feature (compile-time macro PRIO_ENC_ROUND_ROBIN_EN):
//   defined   - rotating-priority search that starts at pointer ptr. After a
//               non-zero accept that selects index k, ptr advances to k+1
//               (wrapping N-1 -> 0).
//   undefined - fixed priority: the lowest set bit wins, and no pointer exists.
//
// Parameters:
//   N      input vector width (N >= 2, need not be a power of two)
//   IDX_W  output index width, derived as $clog2(N); do not override
//   CNT_W  width of the saturating error counter
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   en         block enable; while low, no input is accepted
//   in_vec     request vector, bit i = request i
//   in_valid   in_vec is valid this cycle
//   in_ready   block can accept in_vec this cycle
//              (en & (~out_valid | out_ready))
//   out_idx    encoded index of the selected request
//   out_zero   captured vector had no bit set
//   out_multi  captured vector had more than one bit set
//   out_valid  out_idx and the flags are valid
//   out_ready  consumer takes the output this cycle
//   err_cnt    saturating count of accepted zero or multi-hot vectors
//   err_clr    synchronous clear of err_cnt; wins over a same-cycle increment
// -----------------------------------------------------------------------------
module prio_encoder_hs #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_multi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    // Returns the index of the lowest set bit, or 0 for an all-zero vector.
    function automatic logic [IDX_W-1:0] enc_lowest(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // True when more than one bit is set. Clearing the lowest set bit leaves
    // a non-zero value only if another bit was set.
    function automatic logic is_multi(input logic [N-1:0] v);
        return (v & (v - N'(1))) != '0;
    endfunction

    // Saturating increment: the counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    // Search order starts at p and runs up, wrapping past N-1.
    // The vector is rotated so that bit p lands at position 0. A lowest-bit
    // search then gives the offset from p, which is mapped back modulo N.
    function automatic logic [IDX_W-1:0] enc_rotated(input logic [N-1:0] v,
                                                     input logic [IDX_W-1:0] p);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [IDX_W:0] sum;
        dbl = {v, v} >> p;
        rot = dbl[N-1:0];
        sum = {1'b0, p} + {1'b0, enc_lowest(rot)};
        if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
        return sum[IDX_W-1:0];
    endfunction

    // Pointer successor of the selected index, wrapping N-1 -> 0.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] k);
        return (k == IDX_W'(N - 1)) ? '0 : k + 1'b1;
    endfunction
`endif

    logic             accept_p0;
    logic [IDX_W-1:0] idx_p0;
    logic             zero_p0;
    logic             multi_p0;

    logic             vld_p1;
    logic [IDX_W-1:0] idx_p1;
    logic             zero_p1;
    logic             multi_p1;
    logic [CNT_W-1:0] err_p1;

    // ---- stage p0: handshake and combinational encode of in_vec ----
    assign in_ready  = en & (~vld_p1 | out_ready);
    assign accept_p0 = in_valid & in_ready;
    assign zero_p0   = (in_vec == '0);
    assign multi_p0  = is_multi(in_vec);

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;

    assign idx_p0 = enc_rotated(in_vec, ptr);

    // A zero vector selects nothing, so the pointer stays where it is.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept_p0 && !zero_p0) begin
            ptr <= next_ptr(idx_p0);
        end
    end
`else
    assign idx_p0 = enc_lowest(in_vec);
`endif

    // ---- stage p1: output register and error counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
            zero_p1  <= 1'b0;
            multi_p1 <= 1'b0;
            err_p1   <= '0;
        end else begin
            if (accept_p0) begin
                vld_p1   <= 1'b1;
                idx_p1   <= idx_p0;
                zero_p1  <= zero_p0;
                multi_p1 <= multi_p0;
            end else if (out_ready) begin
                // Drain without refill: data keeps its last value.
                vld_p1 <= 1'b0;
            end

            if (err_clr) begin
                err_p1 <= '0;
            end else if (accept_p0 && (zero_p0 || multi_p0)) begin
                err_p1 <= sat_inc(err_p1);
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_idx   = idx_p1;
    assign out_zero  = zero_p1;
    assign out_multi = multi_p1;
    assign err_cnt   = err_p1;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// -----------------------------------------------------------------------------
// tb_prio_encoder_hs
//
// Directed bench for prio_encoder_hs. Instance dut uses N=4 and CNT_W=8. A
// second instance, dut2, uses N=4 and CNT_W=2 so the counter saturation can be
// exercised; it shares clk, rst, en and out_ready with dut.
// -----------------------------------------------------------------------------
module tb_prio_encoder_hs;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] in_vec;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] out_idx;
    logic       out_zero;
    logic       out_multi;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] err_cnt;
    logic       err_clr;

    logic [3:0] in_vec2;
    logic       in_valid2;
    logic       in_ready2;
    logic [1:0] out_idx2;
    logic       out_zero2;
    logic       out_multi2;
    logic       out_valid2;
    logic [1:0] err_cnt2;
    logic       err_clr2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    prio_encoder_hs #(.N(N), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
        .out_idx(out_idx), .out_zero(out_zero), .out_multi(out_multi),
        .out_valid(out_valid), .out_ready(out_ready),
        .err_cnt(err_cnt), .err_clr(err_clr)
    );

    prio_encoder_hs #(.N(N), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en),
        .in_vec(in_vec2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_idx(out_idx2), .out_zero(out_zero2), .out_multi(out_multi2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .err_cnt(err_cnt2), .err_clr(err_clr2)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Checks all registered outputs of dut at once.
    task automatic chk_out(input string tag, input logic v, input logic [1:0] idx,
                           input logic z, input logic m);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".idx"},   32'(out_idx),   32'(idx));
        chk({tag, ".zero"},  32'(out_zero),  32'(z));
        chk({tag, ".multi"}, 32'(out_multi), 32'(m));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_vec = '0; in_valid = 1'b0;
        out_ready = 1'b1; err_clr = 1'b0;
        in_vec2 = '0; in_valid2 = 1'b0; err_clr2 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_out("reset", 1'b0, 2'd0, 1'b0, 1'b0);
        chk("reset.err", 32'(err_cnt), 0);
        chk("reset.err2", 32'(err_cnt2), 0);

        // One-hot stream at full throughput
        in_valid = 1'b1;
        in_vec = 4'b0001; tick(); chk_out("oh0", 1'b1, 2'd0, 1'b0, 1'b0);
        in_vec = 4'b0010; tick(); chk_out("oh1", 1'b1, 2'd1, 1'b0, 1'b0);
        in_vec = 4'b0100; tick(); chk_out("oh2", 1'b1, 2'd2, 1'b0, 1'b0);
        in_vec = 4'b1000; tick(); chk_out("oh3", 1'b1, 2'd3, 1'b0, 1'b0);
        in_valid = 1'b0;  tick(); chk_out("drain", 1'b0, 2'd3, 1'b0, 1'b0);
        chk("oh.err", 32'(err_cnt), 0);

        // Zero and multi-hot vectors
        in_valid = 1'b1;
        in_vec = 4'b0000; tick(); chk_out("zero", 1'b1, 2'd0, 1'b1, 1'b0);
        chk("zero.err", 32'(err_cnt), 1);
        in_vec = 4'b0110; tick(); chk_out("multi", 1'b1, 2'd1, 1'b0, 1'b1);
        chk("multi.err", 32'(err_cnt), 2);

        // Backpressure: output holds while in_ready stays low
        in_vec = 4'b0100; tick(); chk_out("bp.first", 1'b1, 2'd2, 1'b0, 1'b0);
        out_ready = 1'b0; in_vec = 4'b1000; #1;
        chk("bp.in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp.hold", 1'b1, 2'd2, 1'b0, 1'b0);
            chk("bp.hold.in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1; #1;
        chk("bp.release.in_ready", 32'(in_ready), 1);
        tick(); chk_out("bp.next", 1'b1, 2'd3, 1'b0, 1'b0);
        in_valid = 1'b0; tick(); chk_out("bp.drain", 1'b0, 2'd3, 1'b0, 1'b0);
        chk("bp.err", 32'(err_cnt), 2);

        // en=0 blocks acceptance regardless of out_ready
        en = 1'b0; #1;
        chk("en0.in_ready.r1", 32'(in_ready), 0);
        out_ready = 1'b0; #1;
        chk("en0.in_ready.r0", 32'(in_ready), 0);
        out_ready = 1'b1; en = 1'b1;

        // en=0 with a pending output: the output still drains
        in_valid = 1'b1; in_vec = 4'b0001; tick();
        chk_out("en.pend", 1'b1, 2'd0, 1'b0, 1'b0);
        en = 1'b0; in_vec = 4'b0010; tick();
        chk_out("en0.drain", 1'b0, 2'd0, 1'b0, 1'b0);
        tick(); chk_out("en0.blocked", 1'b0, 2'd0, 1'b0, 1'b0);
        in_valid = 1'b0; en = 1'b1;

        // Counter clear
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr.err", 32'(err_cnt), 0);

        // Mid-stream reset discards the pending output
        in_valid = 1'b1; in_vec = 4'b0011; tick();
        chk_out("pre_rst", 1'b1, 2'd0, 1'b0, 1'b1);
        chk("pre_rst.err", 32'(err_cnt), 1);
        in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        chk_out("mid_rst", 1'b0, 2'd0, 1'b0, 1'b0);
        chk("mid_rst.err", 32'(err_cnt), 0);
        in_valid = 1'b1; in_vec = 4'b1010; tick();
        chk_out("post_rst", 1'b1, 2'd1, 1'b0, 1'b1);
        in_valid = 1'b0; tick();

`ifdef PRIO_ENC_ROUND_ROBIN_EN
        // Rotating priority: the pointer is 0 again after the reset above
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 1'b1; in_vec = 4'b1111;
        tick(); chk_out("rr0", 1'b1, 2'd0, 1'b0, 1'b1);
        tick(); chk_out("rr1", 1'b1, 2'd1, 1'b0, 1'b1);
        tick(); chk_out("rr2", 1'b1, 2'd2, 1'b0, 1'b1);
        tick(); chk_out("rr3", 1'b1, 2'd3, 1'b0, 1'b1);
        tick(); chk_out("rr4", 1'b1, 2'd0, 1'b0, 1'b1);
        in_vec = 4'b1001; tick(); chk_out("rr.1001", 1'b1, 2'd3, 1'b0, 1'b1);
        in_vec = 4'b0000; tick(); chk_out("rr.zero", 1'b1, 2'd0, 1'b1, 1'b0);
        in_vec = 4'b0011; tick(); chk_out("rr.keep", 1'b1, 2'd0, 1'b0, 1'b1);
        in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 1'b1; in_vec = 4'b0110; tick();
        chk_out("rr.ptr_rst", 1'b1, 2'd1, 1'b0, 1'b1);
        in_valid = 1'b0; tick();
`endif

        // Saturation on the 2-bit counter instance
        in_valid2 = 1'b1; in_vec2 = 4'b0000;
        tick(); chk("sat.1", 32'(err_cnt2), 1);
        tick(); chk("sat.2", 32'(err_cnt2), 2);
        tick(); chk("sat.3", 32'(err_cnt2), 3);
        tick(); chk("sat.4", 32'(err_cnt2), 3);
        tick(); chk("sat.5", 32'(err_cnt2), 3);
        chk("sat.zero_flag", 32'(out_zero2), 1);
        err_clr2 = 1'b1; tick(); err_clr2 = 1'b0;
        chk("sat.clr_wins", 32'(err_cnt2), 0);
        chk("sat.valid", 32'(out_valid2), 1);
        in_valid2 = 1'b0; tick();
        chk("sat.after", 32'(err_cnt2), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
